per_arb2: RTL and testbench

- Two-master arbiter that shares one peripheral-interconnect master port between two requesters, e.g. two APB-to-peripheral bridges.
- Selects one requester per transaction using round-robin priority.
- Forwards the selected request channel to the slave, tracks the single outstanding read, and routes the read response back to its owner.
- Sits between the bridges and the peripheral interconnect.

---
 rtl/per_arb2_if.sv | 35 +++
 rtl/per_arb2.sv | 101 ++++++++++
 tb/tb_per_arb2.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/per_arb2_if.sv
// ---------------------------------------------------------------------------
// per_arb2_if -- one peripheral-interconnect request/response channel.
//
// The requester (master modport) drives:
//   req, add, we, wdata, be
// The responder (slave modport) drives:
//   gnt, r_valid, r_opc, r_rdata
//
// A request is accepted in the cycle where req and gnt are both high.
// A read then completes on a later r_valid.
// ---------------------------------------------------------------------------
interface per_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   add;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    gnt;
    logic                    r_valid;
    logic                    r_opc;
    logic [DATA_WIDTH-1:0]   r_rdata;

    modport master (
        output req, add, we, wdata, be,
        input  gnt, r_valid, r_opc, r_rdata
    );

    modport slave (
        input  req, add, we, wdata, be,
        output gnt, r_valid, r_opc, r_rdata
    );
endinterface

// File: rtl/per_arb2.sv
// ---------------------------------------------------------------------------
// per_arb2 -- two-master round-robin arbiter in front of one peripheral port.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   m0, m1          requester channels (slave side of per_arb2_if)
//   s               shared downstream channel (master side of per_arb2_if)
//   unexp_rvalid_o  one-cycle pulse when a response arrives with no read pending
//
// Behaviour:
//   - One transaction is selected per handshake.
//   - Writes finish at grant, so back-to-back writes can be issued every cycle.
//   - A granted read blocks the port until its response is seen.
//     The response valid is steered to the owner of the read.
//   - Response data and opcode go to both masters unregistered.
// ---------------------------------------------------------------------------
module per_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    per_arb2_if.slave    m0,
    per_arb2_if.slave    m1,
    per_arb2_if.master   s,
    output logic         unexp_rvalid_o
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_RD = 1'b1;

    logic [0:0] state;
    logic       prio;   // 0: m0 wins a tie
    logic       owner;  // master waiting for the read response

    logic       sel;
    logic       hs;
    logic       rsp_ok;

    // prio only moves on a handshake.
    // This keeps a stalled request stable while the slave holds off gnt.
    always_comb begin
        sel = 1'b0;
        if (m0.req && m1.req) begin
            sel = prio;
        end else if (m1.req) begin
            sel = 1'b1;
        end
    end

    // Request channel: the fields follow the selected master.
    // With no requester they follow m0.
    assign s.req   = (state == IDLE) && (m0.req || m1.req);
    assign s.add   = sel ? m1.add   : m0.add;
    assign s.we    = sel ? m1.we    : m0.we;
    assign s.wdata = sel ? m1.wdata : m0.wdata;
    assign s.be    = sel ? m1.be    : m0.be;

    // A grant seen while s.req is low is ignored.
    assign hs     = s.req && s.gnt;
    assign m0.gnt = hs && !sel;
    assign m1.gnt = hs &&  sel;

    // Response valid is only meaningful while a read is pending.
    assign rsp_ok         = (state == WAIT_RD) && s.r_valid;
    assign m0.r_valid     = rsp_ok && !owner;
    assign m1.r_valid     = rsp_ok &&  owner;
    assign unexp_rvalid_o = (state == IDLE) && s.r_valid;

    assign m0.r_opc   = s.r_opc;
    assign m1.r_opc   = s.r_opc;
    assign m0.r_rdata = s.r_rdata;
    assign m1.r_rdata = s.r_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        prio <= ~sel;
                        if (!s.we) begin
                            owner <= sel;
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    // Returning to IDLE here leaves one bubble cycle
                    // before the next grant.
                    if (s.r_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_per_arb2.sv
module tb_per_arb2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic unexp_rvalid_o;
    int   n_cmp = 0;
    int   n_err = 0;

    per_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
    per_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
    per_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

    per_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .s              (s_bus),
        .unexp_rvalid_o (unexp_rvalid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the clock edge.
    // Checks run 1 time unit after that, well away from the next edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic gnts(input string tag, input logic g0, input logic g1);
        #1;
        chk({tag, "_m0gnt"}, 32'(m0_bus.gnt), 32'(g0));
        chk({tag, "_m1gnt"}, 32'(m1_bus.gnt), 32'(g1));
    endtask

    initial begin
        rst_ni = 1'b0;
        m0_bus.req = 0; m0_bus.add = '0; m0_bus.we = 0; m0_bus.wdata = '0; m0_bus.be = '0;
        m1_bus.req = 0; m1_bus.add = '0; m1_bus.we = 0; m1_bus.wdata = '0; m1_bus.be = '0;
        s_bus.gnt = 0; s_bus.r_valid = 0; s_bus.r_opc = 0; s_bus.r_rdata = '0;

        // Reset state
        #12;
        gnts("rst", 0, 0);
        chk("rst_sreq",  32'(s_bus.req), 0);
        chk("rst_unexp", 32'(unexp_rvalid_o), 0);
        chk("rst_rv0",   32'(m0_bus.r_valid), 0);
        chk("rst_rv1",   32'(m1_bus.r_valid), 0);
        rst_ni = 1'b1;
        tick();
        chk("rst_prio",  32'(dut.prio), 0);
        chk("rst_state", 32'(dut.state), 0);

        // Single m0 write
        m0_bus.req = 1; m0_bus.we = 1; m0_bus.add = 32'h1A10_0004;
        m0_bus.wdata = 32'hDEAD_BEEF; m0_bus.be = 4'hF;
        s_bus.gnt = 1;
        gnts("w0", 1, 0);
        chk("w0_sreq",  32'(s_bus.req), 1);
        chk("w0_add",   s_bus.add, 32'h1A10_0004);
        chk("w0_wdata", s_bus.wdata, 32'hDEAD_BEEF);
        chk("w0_we",    32'(s_bus.we), 1);
        chk("w0_be",    32'(s_bus.be), 32'hF);
        tick();
        m0_bus.req = 0;
        chk("w0_prio",  32'(dut.prio), 1);
        chk("w0_state", 32'(dut.state), 0);

        // Single m1 write: prio moves back to 0
        m1_bus.req = 1; m1_bus.we = 1; m1_bus.add = 32'h0000_00B0;
        m1_bus.wdata = 32'h1111_2222; m1_bus.be = 4'h3;
        gnts("w1", 0, 1);
        chk("w1_be", 32'(s_bus.be), 32'h3);
        tick();
        chk("w1_prio", 32'(dut.prio), 0);

        // Both masters write back-to-back: grants alternate m0, m1, m0, m1
        m0_bus.req = 1; m0_bus.add = 32'h0000_00A0;
        for (int k = 0; k < 4; k++) begin
            gnts($sformatf("alt%0d", k), (k % 2) == 0, (k % 2) == 1);
            chk($sformatf("alt%0d_add", k), s_bus.add,
                (k % 2) == 0 ? 32'h0000_00A0 : 32'h0000_00B0);
            tick();
        end

        // Both request while the slave stalls: prio=0, so m0 is held
        s_bus.gnt = 0;
        for (int k = 0; k < 3; k++) begin
            gnts($sformatf("stall%0d", k), 0, 0);
            chk($sformatf("stall%0d_add", k), s_bus.add, 32'h0000_00A0);
            chk($sformatf("stall%0d_prio", k), 32'(dut.prio), 0);
            tick();
        end
        s_bus.gnt = 1;
        gnts("stall3", 1, 0);
        chk("stall3_add", s_bus.add, 32'h0000_00A0);
        tick();
        m1_bus.req = 0;
        m0_bus.req = 0;

        // m1 read (prio=1) while m0 also requests a write
        m1_bus.req = 1; m1_bus.we = 0; m1_bus.add = 32'h0000_00C0;
        m0_bus.req = 1; m0_bus.we = 1; m0_bus.add = 32'h0000_00D0;
        gnts("rd1", 0, 1);
        chk("rd1_we",  32'(s_bus.we), 0);
        chk("rd1_add", s_bus.add, 32'h0000_00C0);
        tick();
        m1_bus.req = 0;
        chk("rd1_state", 32'(dut.state), 1);
        for (int k = 0; k < 2; k++) begin
            gnts($sformatf("wait%0d", k), 0, 0);
            chk($sformatf("wait%0d_sreq", k), 32'(s_bus.req), 0);
            tick();
        end
        s_bus.r_valid = 1; s_bus.r_rdata = 32'h1234_5678; s_bus.r_opc = 1;
        gnts("rsp", 0, 0);
        chk("rsp_rv1",   32'(m1_bus.r_valid), 1);
        chk("rsp_rv0",   32'(m0_bus.r_valid), 0);
        chk("rsp_data1", m1_bus.r_rdata, 32'h1234_5678);
        chk("rsp_data0", m0_bus.r_rdata, 32'h1234_5678);
        chk("rsp_opc0",  32'(m0_bus.r_opc), 1);
        chk("rsp_sreq",  32'(s_bus.req), 0);
        chk("rsp_unexp", 32'(unexp_rvalid_o), 0);
        tick();
        s_bus.r_valid = 0; s_bus.r_opc = 0;
        gnts("after", 1, 0);
        chk("after_add", s_bus.add, 32'h0000_00D0);
        tick();
        m0_bus.req = 0;

        // Unexpected response in IDLE; a grant with no request is ignored
        s_bus.r_valid = 1;
        #1;
        chk("unexp_pulse", 32'(unexp_rvalid_o), 1);
        chk("unexp_rv0",   32'(m0_bus.r_valid), 0);
        chk("unexp_rv1",   32'(m1_bus.r_valid), 0);
        tick();
        s_bus.r_valid = 0;
        #1;
        chk("unexp_end",  32'(unexp_rvalid_o), 0);
        chk("idle_gnt_prio",  32'(dut.prio), 1);
        chk("idle_gnt_state", 32'(dut.state), 0);

        // m0 read, reset mid-wait, then a late response
        m0_bus.req = 1; m0_bus.we = 0; m0_bus.add = 32'h0000_00E0;
        gnts("rd0", 1, 0);
        tick();
        m0_bus.req = 0;
        s_bus.gnt = 0;
        chk("rd0_state", 32'(dut.state), 1);
        tick();
        rst_ni = 0;
        #2;
        chk("mid_rst_state", 32'(dut.state), 0);
        chk("mid_rst_prio",  32'(dut.prio), 0);
        rst_ni = 1;
        tick();
        s_bus.r_valid = 1; s_bus.r_rdata = 32'hCAFE_0001;
        #1;
        chk("late_unexp", 32'(unexp_rvalid_o), 1);
        chk("late_rv0",   32'(m0_bus.r_valid), 0);
        tick();
        s_bus.r_valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
